// File: rtl/pwm_cfg_arbiter_if.sv
// Register-access bus shared by requester A (clk-domain master) and requester B
// (sampled SPI slave). Each requester holds its request until it sees its grant.
interface pwm_cfg_arbiter_if;
   logic       req_a;
   logic       we_a;
   logic [2:0] addr_a;
   logic [7:0] wdata_a;
   logic       gnt_a;
   logic       rvalid_a;
   logic [7:0] rdata_a;

   logic       req_b;
   logic       we_b;
   logic [2:0] addr_b;
   logic [7:0] wdata_b;
   logic       gnt_b;
   logic       rvalid_b;
   logic [7:0] rdata_b;

   // Requester side: drives both request channels, observes grants and read data
   modport master (
      output req_a, we_a, addr_a, wdata_a,
      output req_b, we_b, addr_b, wdata_b,
      input  gnt_a, rvalid_a, rdata_a,
      input  gnt_b, rvalid_b, rdata_b
   );

   // Arbiter side: observes both request channels, returns grants and read data
   modport slave (
      input  req_a, we_a, addr_a, wdata_a,
      input  req_b, we_b, addr_b, wdata_b,
      output gnt_a, rvalid_a, rdata_a,
      output gnt_b, rvalid_b, rdata_b
   );
endinterface

// File: rtl/pwm_cfg_arbiter.sv
// PWM configuration register file shared by two requesters through a
// round-robin arbiter, with a start-triggered sequencer and shadow copies of
// PERIOD/DUTY that only change on period boundaries while the PWM is running.
module pwm_cfg_arbiter #(
   parameter logic [7:0]  ID_VALUE   = 8'hA5,
   parameter logic [15:0] RST_PERIOD = 16'h00FF
) (
   input  logic             clk,
   input  logic             rst_n,
   pwm_cfg_arbiter_if.slave bus,
   input  logic             i_start_ext,
   input  logic             i_period_end,
   output logic             o_pwm_en,
   output logic [15:0]      o_period,
   output logic [15:0]      o_duty
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } seqState_t;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_PER_L  = 3'd1;
   localparam logic [2:0] ADDR_PER_H  = 3'd2;
   localparam logic [2:0] ADDR_DUTY_L = 3'd3;
   localparam logic [2:0] ADDR_DUTY_H = 3'd4;
   localparam logic [2:0] ADDR_STATUS = 3'd5;
   localparam logic [2:0] ADDR_PULSE  = 3'd6;

   seqState_t   r_state;
   logic [2:0]  r_ctrl;
   logic [15:0] r_periodReg;
   logic [15:0] r_dutyReg;
   logic [7:0]  r_pulseLimit;
   logic [7:0]  r_pulseCount;
   logic        r_pending;
   logic        r_preferB;
   logic        r_syncMeta;
   logic        r_syncStable;
   logic        r_syncPrev;
   logic        r_pwmEn;
   logic [15:0] r_shadowPeriod;
   logic [15:0] r_shadowDuty;
   logic        r_rvalidA;
   logic        r_rvalidB;
   logic [7:0]  r_rdataA;
   logic [7:0]  r_rdataB;

   logic        w_gntA;
   logic        w_gntB;
   logic        w_write;
   logic [2:0]  w_addr;
   logic [7:0]  w_wdata;
   logic [7:0]  w_readData;
   logic [15:0] w_periodNext;
   logic [15:0] w_dutyNext;
   logic        w_wrCfg;
   logic        w_shadowLoad;
   logic        w_startEvt;
   logic [7:0]  w_countInc;
   logic        w_limitHit;
   logic        w_enable;
   logic        w_extEn;
   logic        w_oneshot;

   assign w_enable  = r_ctrl[0];
   assign w_extEn   = r_ctrl[1];
   assign w_oneshot = r_ctrl[2];

   // Grant at most one requester per cycle; on a tie the preferred port wins
   always_comb begin
      w_gntA = bus.req_a & (~bus.req_b | ~r_preferB);
      w_gntB = bus.req_b & ~w_gntA;
   end

   // Steer the granted requester's command onto the single internal access path
   always_comb begin
      w_write = (w_gntA & bus.we_a) | (w_gntB & bus.we_b);
      w_addr  = w_gntB ? bus.addr_b  : bus.addr_a;
      w_wdata = w_gntB ? bus.wdata_b : bus.wdata_a;
   end

   // Register values as they will be after this edge, so a write coinciding with a shadow load is seen
   always_comb begin
      w_periodNext = r_periodReg;
      w_dutyNext   = r_dutyReg;
      if (w_write) begin
         case (w_addr)
            ADDR_PER_L:  w_periodNext[7:0]  = w_wdata;
            ADDR_PER_H:  w_periodNext[15:8] = w_wdata;
            ADDR_DUTY_L: w_dutyNext[7:0]    = w_wdata;
            ADDR_DUTY_H: w_dutyNext[15:8]   = w_wdata;
            default: ;
         endcase
      end
      w_wrCfg = w_write && (w_addr >= ADDR_PER_L) && (w_addr <= ADDR_DUTY_H);
   end

   // Register read multiplexer, sampled on the grant edge
   always_comb begin
      case (w_addr)
         ADDR_CTRL:   w_readData = {5'b0, r_ctrl};
         ADDR_PER_L:  w_readData = r_periodReg[7:0];
         ADDR_PER_H:  w_readData = r_periodReg[15:8];
         ADDR_DUTY_L: w_readData = r_dutyReg[7:0];
         ADDR_DUTY_H: w_readData = r_dutyReg[15:8];
         ADDR_STATUS: w_readData = {5'b0, r_state, r_pending};
         ADDR_PULSE:  w_readData = r_pulseLimit;
         default:     w_readData = ID_VALUE;
      endcase
   end

   // Start events and pulse-limit detection for the sequencer
   always_comb begin
      w_startEvt   = r_syncStable & ~r_syncPrev;
      w_countInc   = (r_pulseCount == 8'hFF) ? 8'hFF : r_pulseCount + 8'd1;
      w_limitHit   = w_oneshot && (r_pulseLimit != 8'd0) && (w_countInc >= r_pulseLimit);
      w_shadowLoad = (r_state == ST_IDLE) || (r_state == ST_ARMED) ||
                     ((r_state == ST_RUN) && i_period_end);
   end

   // Round-robin pointer: after serving one port, prefer the other on the next tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_preferB <= 1'b0;
      end else if (w_gntA) begin
         r_preferB <= 1'b1;
      end else if (w_gntB) begin
         r_preferB <= 1'b0;
      end
   end

   // Writable configuration registers; STATUS and ID have no storage so writes there vanish
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl       <= 3'b0;
         r_periodReg  <= RST_PERIOD;
         r_dutyReg    <= 16'h0000;
         r_pulseLimit <= 8'h00;
      end else begin
         r_periodReg <= w_periodNext;
         r_dutyReg   <= w_dutyNext;
         if (w_write && (w_addr == ADDR_CTRL)) begin
            r_ctrl <= w_wdata[2:0];
         end
         if (w_write && (w_addr == ADDR_PULSE)) begin
            r_pulseLimit <= w_wdata;
         end
      end
   end

   // Per-port read response: rvalid pulses for one cycle, rdata holds until the next read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalidA <= 1'b0;
         r_rvalidB <= 1'b0;
         r_rdataA  <= 8'h00;
         r_rdataB  <= 8'h00;
      end else begin
         r_rvalidA <= w_gntA & ~bus.we_a;
         r_rvalidB <= w_gntB & ~bus.we_b;
         if (w_gntA && !bus.we_a) begin
            r_rdataA <= w_readData;
         end
         if (w_gntB && !bus.we_b) begin
            r_rdataB <= w_readData;
         end
      end
   end

   // Two-flop synchronizer for the external start plus a delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_syncMeta   <= 1'b0;
         r_syncStable <= 1'b0;
         r_syncPrev   <= 1'b0;
      end else begin
         r_syncMeta   <= i_start_ext;
         r_syncStable <= r_syncMeta;
         r_syncPrev   <= r_syncStable;
      end
   end

   // Shadow period/duty with duty clamped to period; pending marks a RUN-time edit not yet applied
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadowPeriod <= RST_PERIOD;
         r_shadowDuty   <= 16'h0000;
         r_pending      <= 1'b0;
      end else if (w_shadowLoad) begin
         r_shadowPeriod <= w_periodNext;
         r_shadowDuty   <= (w_dutyNext > w_periodNext) ? w_periodNext : w_dutyNext;
         r_pending      <= 1'b0;
      end else if ((r_state == ST_RUN) && w_wrCfg) begin
         r_pending <= 1'b1;
      end
   end

   // Sequencer with registered pwm enable and the RUN pulse counter; clearing enable always returns to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_pwmEn      <= 1'b0;
         r_pulseCount <= 8'h00;
      end else if (!w_enable) begin
         r_state <= ST_IDLE;
         r_pwmEn <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_extEn) begin
                  r_state <= ST_ARMED;
                  r_pwmEn <= 1'b0;
               end else begin
                  r_state      <= ST_RUN;
                  r_pwmEn      <= 1'b1;
                  r_pulseCount <= 8'h00;
               end
            end
            ST_ARMED: begin
               if (w_startEvt) begin
                  r_state      <= ST_RUN;
                  r_pwmEn      <= 1'b1;
                  r_pulseCount <= 8'h00;
               end
            end
            ST_RUN: begin
               if (i_period_end) begin
                  r_pulseCount <= w_countInc;
                  if (w_limitHit) begin
                     r_state <= ST_DONE;
                     r_pwmEn <= 1'b0;
                  end
               end
            end
            default: begin
               r_pwmEn <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt_a    = w_gntA;
   assign bus.gnt_b    = w_gntB;
   assign bus.rvalid_a = r_rvalidA;
   assign bus.rvalid_b = r_rvalidB;
   assign bus.rdata_a  = r_rdataA;
   assign bus.rdata_b  = r_rdataB;
   assign o_pwm_en     = r_pwmEn;
   assign o_period     = r_shadowPeriod;
   assign o_duty       = r_shadowDuty;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Testbench for pwm_cfg_arbiter: directed sequencer scenarios followed by
// randomized register traffic from both ports, checked against a register-map
// model that tracks byte contents, grant order and the expected shadow outputs.
module tb_pwm_cfg_arbiter;

   localparam logic [7:0] ID_EXPECTED = 8'hA5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        startExt;
   logic        periodEnd;
   logic        pwmEn;
   logic [15:0] period;
   logic [15:0] duty;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [7:0] mRegs [0:7];
   int         mLastPort;

   pwm_cfg_arbiter_if bus ();

   pwm_cfg_arbiter #(
      .ID_VALUE   (8'hA5),
      .RST_PERIOD (16'h00FF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .i_start_ext  (startExt),
      .i_period_end (periodEnd),
      .o_pwm_en     (pwmEn),
      .o_period     (period),
      .o_duty       (duty)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Hard stop in case some wait never returns
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Register map as the specification describes it, reset values included
   function automatic void modelReset();
      mRegs[0]  = 8'h00;
      mRegs[1]  = 8'hFF;
      mRegs[2]  = 8'h00;
      mRegs[3]  = 8'h00;
      mRegs[4]  = 8'h00;
      mRegs[5]  = 8'h00;
      mRegs[6]  = 8'h00;
      mRegs[7]  = 8'h00;
      mLastPort = -1;
   endfunction

   function automatic void modelWrite(input logic [2:0] addr, input logic [7:0] wd);
      if (addr == 3'd0) begin
         mRegs[0] = {5'b0, wd[2:0]};
      end else if (addr != 3'd5 && addr != 3'd7) begin
         mRegs[addr] = wd;
      end
   endfunction

   // Valid while the sequencer sits in IDLE with nothing pending
   function automatic logic [7:0] modelRead(input logic [2:0] addr);
      case (addr)
         3'd5:    return 8'h00;
         3'd7:    return ID_EXPECTED;
         default: return mRegs[addr];
      endcase
   endfunction

   function automatic logic [15:0] expPeriod();
      return {mRegs[2], mRegs[1]};
   endfunction

   function automatic logic [15:0] expDuty();
      logic [15:0] p;
      logic [15:0] d;
      p = {mRegs[2], mRegs[1]};
      d = {mRegs[4], mRegs[3]};
      return (d > p) ? p : d;
   endfunction

   function automatic logic gntOf(input int p);
      return (p == 1) ? bus.gnt_b : bus.gnt_a;
   endfunction

   function automatic logic rvalidOf(input int p);
      return (p == 1) ? bus.rvalid_b : bus.rvalid_a;
   endfunction

   function automatic logic [7:0] rdataOf(input int p);
      return (p == 1) ? bus.rdata_b : bus.rdata_a;
   endfunction

   task automatic driveReq(input int p, input logic req, input logic we, input logic [2:0] addr, input logic [7:0] wd);
      if (p == 1) begin
         bus.req_b = req; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd;
      end else begin
         bus.req_a = req; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd;
      end
   endtask

   // Single access on one port; entered and left at a falling edge
   task automatic applyStimulus(input int p, input logic we, input logic [2:0] addr, input logic [7:0] wd, output logic [7:0] rd);
      int   waited;
      logic granted;
      waited = 0;
      driveReq(p, 1'b1, we, addr, wd);
      #1;
      granted = gntOf(p);
      while (!granted && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
         granted = gntOf(p);
      end
      checkOutput("grant_seen", {31'b0, granted}, 32'd1);
      @(posedge clk);
      #1;
      driveReq(p, 1'b0, 1'b0, 3'd0, 8'h00);
      if (granted) begin
         mLastPort = p;
         if (we) modelWrite(addr, wd);
      end
      rd = rdataOf(p);
      if (!we) begin
         checkOutput("rvalid_after_gnt", {31'b0, rvalidOf(p)}, 32'd1);
         @(posedge clk);
         #1;
         checkOutput("rvalid_one_cycle", {31'b0, rvalidOf(p)}, 32'd0);
      end
      @(negedge clk);
   endtask

   // Both ports request together; grant order comes from the model's last-served port
   task automatic pairAccess(input logic weA, input logic [2:0] addrA, input logic [7:0] wdA,
                             input logic weB, input logic [2:0] addrB, input logic [7:0] wdB);
      logic       opWe [2];
      logic [2:0] opAddr [2];
      logic [7:0] opData [2];
      logic [7:0] expRead;
      int         first;
      int         second;
      opWe[0] = weA; opAddr[0] = addrA; opData[0] = wdA;
      opWe[1] = weB; opAddr[1] = addrB; opData[1] = wdB;
      first  = (mLastPort == 0) ? 1 : 0;
      second = 1 - first;
      driveReq(0, 1'b1, weA, addrA, wdA);
      driveReq(1, 1'b1, weB, addrB, wdB);
      #1;
      checkOutput("tie_gnt_a", {31'b0, bus.gnt_a}, {31'b0, first == 0});
      checkOutput("tie_gnt_b", {31'b0, bus.gnt_b}, {31'b0, first == 1});
      for (int k = 0; k < 2; k++) begin
         int p;
         p = (k == 0) ? first : second;
         expRead = modelRead(opAddr[p]);
         if (k == 1) checkOutput("second_gnt", {31'b0, gntOf(p)}, 32'd1);
         @(posedge clk);
         #1;
         driveReq(p, 1'b0, 1'b0, 3'd0, 8'h00);
         mLastPort = p;
         if (opWe[p]) modelWrite(opAddr[p], opData[p]);
         checkOutput("rvalid_pair", {31'b0, rvalidOf(p)}, {31'b0, !opWe[p]});
         if (!opWe[p]) checkOutput("rdata_pair", {24'b0, rdataOf(p)}, {24'b0, expRead});
         if (k == 1) checkOutput("rvalid_first_drop", {31'b0, rvalidOf(first)}, 32'd0);
      end
      @(negedge clk);
      checkOutput("period_model", {16'b0, period}, {16'b0, expPeriod()});
      checkOutput("duty_model", {16'b0, duty}, {16'b0, expDuty()});
   endtask

   task automatic pulsePeriodEnd();
      periodEnd = 1'b1;
      @(posedge clk);
      #1;
      periodEnd = 1'b0;
      @(negedge clk);
   endtask

   initial begin : mainSeq
      logic [7:0] rd;
      logic       rWe;
      logic       rWeB;
      logic [2:0] rAddr;
      logic [2:0] rAddrB;
      logic [7:0] rData;
      logic [7:0] rDataB;
      logic [7:0] expRd;
      int         rPort;

      rst_n     = 1'b0;
      startExt  = 1'b0;
      periodEnd = 1'b0;
      driveReq(0, 1'b0, 1'b0, 3'd0, 8'h00);
      driveReq(1, 1'b0, 1'b0, 3'd0, 8'h00);
      modelReset();
      repeat (3) @(negedge clk);

      // Reset values
      checkOutput("reset_pwm_en", {31'b0, pwmEn}, 32'd0);
      checkOutput("reset_period", {16'b0, period}, 32'h00FF);
      checkOutput("reset_duty", {16'b0, duty}, 32'h0000);
      checkOutput("reset_rvalid_a", {31'b0, bus.rvalid_a}, 32'd0);
      checkOutput("reset_rvalid_b", {31'b0, bus.rvalid_b}, 32'd0);
      checkOutput("reset_rdata_a", {24'b0, bus.rdata_a}, 32'd0);
      checkOutput("reset_rdata_b", {24'b0, bus.rdata_b}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Simultaneous writes: A (PERIOD L) first after reset, then B (DUTY L)
      pairAccess(1'b1, 3'd1, 8'h10, 1'b1, 3'd3, 8'h08);
      checkOutput("dual_write_period", {16'b0, period}, 32'h0010);
      checkOutput("dual_write_duty", {16'b0, duty}, 32'h0008);

      // STATUS after reset, ID on port B
      applyStimulus(0, 1'b0, 3'd5, 8'h00, rd);
      checkOutput("status_after_reset", {24'b0, rd}, 32'h00);
      applyStimulus(1, 1'b0, 3'd7, 8'h00, rd);
      checkOutput("id_read_b", {24'b0, rd}, 32'hA5);

      // External start: ARMED, then RUN three edges after start_ext rises
      applyStimulus(0, 1'b1, 3'd0, 8'h03, rd);
      @(negedge clk);
      applyStimulus(1, 1'b0, 3'd5, 8'h00, rd);
      checkOutput("status_armed", {24'b0, rd}, 32'h02);
      checkOutput("pwm_en_armed", {31'b0, pwmEn}, 32'd0);
      startExt = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("pwm_en_two_edges", {31'b0, pwmEn}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("pwm_en_three_edges", {31'b0, pwmEn}, 32'd1);
      @(negedge clk);
      startExt = 1'b0;
      repeat (3) @(negedge clk);
      startExt = 1'b1;
      repeat (5) @(negedge clk);
      startExt = 1'b0;
      checkOutput("second_edge_in_run", {31'b0, pwmEn}, 32'd1);
      applyStimulus(0, 1'b0, 3'd5, 8'h00, rd);
      checkOutput("status_run", {24'b0, rd}, 32'h04);
      applyStimulus(0, 1'b1, 3'd0, 8'h00, rd);
      @(negedge clk);
      checkOutput("pwm_en_disabled", {31'b0, pwmEn}, 32'd0);
      applyStimulus(1, 1'b0, 3'd5, 8'h00, rd);
      checkOutput("status_disabled", {24'b0, rd}, 32'h00);

      // One-shot of three periods
      applyStimulus(0, 1'b1, 3'd6, 8'h03, rd);
      applyStimulus(1, 1'b1, 3'd0, 8'h05, rd);
      @(negedge clk);
      checkOutput("oneshot_running", {31'b0, pwmEn}, 32'd1);
      pulsePeriodEnd();
      pulsePeriodEnd();
      checkOutput("oneshot_two_periods", {31'b0, pwmEn}, 32'd1);
      pulsePeriodEnd();
      checkOutput("oneshot_done_pwm", {31'b0, pwmEn}, 32'd0);
      applyStimulus(0, 1'b0, 3'd5, 8'h00, rd);
      checkOutput("status_done", {24'b0, rd}, 32'h06);
      applyStimulus(0, 1'b1, 3'd0, 8'h00, rd);
      @(negedge clk);
      applyStimulus(1, 1'b0, 3'd5, 8'h00, rd);
      checkOutput("status_done_to_idle", {24'b0, rd}, 32'h00);

      // Duty edit during RUN is held back, then clamped to period
      applyStimulus(0, 1'b1, 3'd1, 8'd100, rd);
      applyStimulus(0, 1'b1, 3'd2, 8'h00, rd);
      checkOutput("period_idle_load", {16'b0, period}, 32'd100);
      applyStimulus(0, 1'b1, 3'd0, 8'h01, rd);
      @(negedge clk);
      checkOutput("run_continuous", {31'b0, pwmEn}, 32'd1);
      applyStimulus(1, 1'b1, 3'd3, 8'hC8, rd);
      applyStimulus(1, 1'b1, 3'd4, 8'h00, rd);
      applyStimulus(0, 1'b0, 3'd5, 8'h00, rd);
      checkOutput("status_pending", {24'b0, rd}, 32'h05);
      checkOutput("duty_held_in_run", {16'b0, duty}, 32'd8);
      pulsePeriodEnd();
      checkOutput("duty_clamped", {16'b0, duty}, 32'd100);
      checkOutput("period_after_load", {16'b0, period}, 32'd100);
      applyStimulus(0, 1'b0, 3'd5, 8'h00, rd);
      checkOutput("status_pending_cleared", {24'b0, rd}, 32'h04);

      // Write landing on the same edge as period_end reaches the shadow
      periodEnd = 1'b1;
      driveReq(0, 1'b1, 1'b1, 3'd3, 8'h20);
      #1;
      checkOutput("same_cycle_gnt", {31'b0, bus.gnt_a}, 32'd1);
      @(posedge clk);
      #1;
      periodEnd = 1'b0;
      driveReq(0, 1'b0, 1'b0, 3'd0, 8'h00);
      mLastPort = 0;
      @(negedge clk);
      checkOutput("same_cycle_duty", {16'b0, duty}, 32'h0020);
      applyStimulus(1, 1'b0, 3'd5, 8'h00, rd);
      checkOutput("same_cycle_no_pending", {24'b0, rd}, 32'h04);

      // Asynchronous reset in the middle of RUN
      checkOutput("pre_reset_run", {31'b0, pwmEn}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_pwm_en", {31'b0, pwmEn}, 32'd0);
      checkOutput("async_reset_period", {16'b0, period}, 32'h00FF);
      checkOutput("async_reset_duty", {16'b0, duty}, 32'h0000);
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(0, 1'b0, 3'd5, 8'h00, rd);
      checkOutput("status_after_release", {24'b0, rd}, 32'h00);
      applyStimulus(0, 1'b0, 3'd0, 8'h00, rd);
      checkOutput("ctrl_after_release", {24'b0, rd}, 32'h00);
      applyStimulus(1, 1'b0, 3'd1, 8'h00, rd);
      checkOutput("period_l_after_release", {24'b0, rd}, 32'hFF);

      // Randomized traffic in IDLE (enable kept clear) against the register model
      for (int i = 0; i < 40; i++) begin
         rWe    = 1'($urandom_range(0, 1));
         rWeB   = 1'($urandom_range(0, 1));
         rAddr  = 3'($urandom_range(0, 7));
         rAddrB = 3'($urandom_range(0, 7));
         rData  = 8'($urandom);
         rDataB = 8'($urandom);
         if (rAddr == 3'd0) rData = rData & 8'hFE;
         if (rAddrB == 3'd0) rDataB = rDataB & 8'hFE;
         if ($urandom_range(0, 2) == 0) begin
            rPort = int'($urandom_range(0, 1));
            expRd = modelRead(rAddr);
            applyStimulus(rPort, rWe, rAddr, rData, rd);
            if (!rWe) checkOutput("rand_read", {24'b0, rd}, {24'b0, expRd});
            checkOutput("rand_period", {16'b0, period}, {16'b0, expPeriod()});
            checkOutput("rand_duty", {16'b0, duty}, {16'b0, expDuty()});
         end else begin
            pairAccess(rWe, rAddr, rData, rWeB, rAddrB, rDataB);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
